// File: rtl/mem_arbiter.sv
// Single RAM port shared by icache and dcache: dcache priority, starvation counter guarantees icache service.
// Optional watchdog abort of a stuck grant is compiled in with MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        arb_timeout
);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  state_t     state;
  logic [3:0] starve_cnt;
  logic       dreq, dgo, access, error, granted_req, done, expire;

  assign dreq        = dREN | dWEN;
  assign dgo         = dreq && !(iREN && starve_cnt == 4'(STARVE_MAX));
  assign access      = (ramstate == RAM_ACCESS);
  assign error       = (ramstate == RAM_ERROR);
  // Request still held by the current grant holder; a drop aborts the grant.
  assign granted_req = (state == DGRANT && dreq) || (state == IGRANT && iREN);
  assign done        = granted_req && access;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] timer;
  assign expire = granted_req && !access && !error && (timer == 8'(TIMEOUT));
`else
  assign expire = 1'b0;
`endif

  assign arb_timeout = expire;

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    case (state)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~(dreq && access);
        dload    = ramload;
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = ~(iREN && access);
        iload   = ramload;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      timer      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (dgo)
            state <= DGRANT;
          else if (iREN)
            state <= IGRANT;
        end
        DGRANT, IGRANT: begin
          if (!granted_req || access || error || expire)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A watchdog abort of a dcache grant counts against the icache like a completion.
      if (!iREN)
        starve_cnt <= '0;
      else if (state == DGRANT && (done || expire)) begin
        if (starve_cnt < 4'(STARVE_MAX))
          starve_cnt <= starve_cnt + 4'd1;
      end else if (state == IGRANT && done)
        starve_cnt <= '0;

`ifdef MEM_ARB_TIMEOUT_EN
      if (state == IDLE)
        timer <= '0;
      else if (!access)
        timer <= timer + 8'd1;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter: per-cycle table plus starvation, reset and watchdog sequences.
module tb_mem_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;
  localparam logic [31:0] A = 32'h0000_0040, D = 32'h0000_0100, S = 32'hDEADBEEF;

  logic        CLK = 1'b0, nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = A, daddr = D, dstore = S, ramload = '0;
  logic [1:0]  ramstate = FREE;
  logic        iwait, dwait, ramREN, ramWEN, arb_timeout;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int vecs = 0;
  int miss = 0;

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_timeout(arb_timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  ctl;   // {iREN, dREN, dWEN}
    logic [1:0]  rs;
    logic [31:0] rl;
    logic [3:0]  exp;   // {iwait, dwait, ramREN, ramWEN}
    logic [31:0] addr;
    logic [31:0] st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [2:0] ctl, input logic [1:0] rs, input logic [31:0] rl,
                     input logic [3:0] exp, input logic [31:0] addr, input logic [31:0] st);
    vec_t v;
    v.ctl = ctl; v.rs = rs; v.rl = rl; v.exp = exp; v.addr = addr; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] want);
    vecs++;
    if (got !== want) begin
      miss++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    int dcnt, pulses, first, g0;
    logic got_i, dlow, held, after1, after2;
    logic [31:0] want_load, got_load;

    // Reset holds outputs idle even with requests present.
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    #3;
    check("reset_outputs", 128'({iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, arb_timeout}),
          128'({4'b1100, 32'h0, 32'h0, 1'b0}));
    check("reset_starve", 128'(dut.starve_cnt), 128'(4'd0));
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    @(posedge CLK); #2 nRST = 1'b1;

    // icache read, ACCESS on 2nd grant cycle
    add(3'b100, FREE, 32'h0,        4'b1100, 32'h0, 32'h0);
    add(3'b100, BUSY, 32'h0,        4'b1110, A,     32'h0);
    add(3'b100, ACC,  32'h8C010004, 4'b0110, A,     32'h0);
    add(3'b000, FREE, 32'h0,        4'b1100, 32'h0, 32'h0);
    // simultaneous iREN/dWEN: dcache write first, bubble, then icache
    add(3'b101, FREE, 32'h0,        4'b1100, 32'h0, 32'h0);
    add(3'b101, BUSY, 32'h0,        4'b1101, D,     S);
    add(3'b101, ACC,  32'h12345678, 4'b1001, D,     S);
    add(3'b100, FREE, 32'h0,        4'b1100, 32'h0, 32'h0);
    add(3'b100, ACC,  32'hCAFEF00D, 4'b0110, A,     32'h0);
    add(3'b000, FREE, 32'h0,        4'b1100, 32'h0, 32'h0);
    // dcache drops mid-grant, then icache drops mid-grant
    add(3'b110, FREE, 32'h0,        4'b1100, 32'h0, 32'h0);
    add(3'b110, BUSY, 32'h0,        4'b1110, D,     S);
    add(3'b100, BUSY, 32'h0,        4'b1100, D,     S);
    add(3'b100, FREE, 32'h0,        4'b1100, 32'h0, 32'h0);
    add(3'b100, BUSY, 32'h0,        4'b1110, A,     32'h0);
    add(3'b000, BUSY, 32'h0,        4'b1100, A,     32'h0);
    add(3'b000, FREE, 32'h0,        4'b1100, 32'h0, 32'h0);
    // ERROR then retry
    add(3'b010, FREE, 32'h0,        4'b1100, 32'h0, 32'h0);
    add(3'b010, ERR,  32'h0,        4'b1110, D,     S);
    add(3'b010, FREE, 32'h0,        4'b1100, 32'h0, 32'h0);
    add(3'b010, ACC,  32'h0BADF00D, 4'b1010, D,     S);
    add(3'b000, FREE, 32'h0,        4'b1100, 32'h0, 32'h0);
    // dREN and dWEN together: write wins
    add(3'b011, FREE, 32'h0,        4'b1100, 32'h0, 32'h0);
    add(3'b011, ACC,  32'h5A5A5A5A, 4'b1001, D,     S);
    add(3'b000, FREE, 32'h0,        4'b1100, 32'h0, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      tick();
      {iREN, dREN, dWEN} = tbl[i].ctl;
      ramstate = tbl[i].rs;
      ramload  = tbl[i].rl;
      #2;
      want_load = (tbl[i].exp[3] == 1'b0 || tbl[i].exp[2] == 1'b0) ? tbl[i].rl : 32'h0;
      got_load  = !iwait ? iload : (!dwait ? dload : 32'h0);
      check($sformatf("vec%0d", i),
            128'({iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, got_load}),
            128'({tbl[i].exp, tbl[i].addr, tbl[i].st, want_load}));
    end

    // Starvation: both requesters held, RAM answers ACCESS whenever enabled.
    dcnt = 0; got_i = 1'b0;
    for (int c = 0; c < 60 && !got_i; c++) begin
      tick();
      iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; ramstate = FREE;
      #1;
      if (ramREN || ramWEN) ramstate = ACC;
      #1;
      if (!dwait) dcnt++;
      if (!iwait) got_i = 1'b1;
    end
    check("starve_icache_served", 128'(got_i), 128'(1'b1));
    check("starve_dcache_count", 128'(dcnt), 128'(4));
    tick();
    dREN = 1'b0; ramstate = FREE;
    #2;
    check("starve_cleared", 128'(dut.starve_cnt), 128'(4'd0));
    iREN = 1'b0;
    tick();

    // Async reset in the middle of a dcache grant.
    dREN = 1'b1; ramstate = FREE;
    tick();
    ramstate = BUSY;
    #2;
    check("rst_pre_grant", 128'({ramREN, ramaddr}), 128'({1'b1, D}));
    #1 nRST = 1'b0;
    #1;
    check("rst_async", 128'({ramREN, ramWEN, dwait, ramaddr}), 128'({3'b001, 32'h0}));
    tick();
    nRST = 1'b1; ramstate = FREE;
    #2;
    check("rst_idle_after", 128'(ramREN), 128'(1'b0));
    tick();
    ramstate = BUSY;
    #2;
    check("rst_regrant", 128'({ramREN, ramaddr}), 128'({1'b1, D}));
    dREN = 1'b0; ramstate = FREE;
    tick(); tick();

    // Stuck BUSY dcache read.
    pulses = 0; first = -1; g0 = -1; dlow = 1'b0; held = 1'b1; after1 = 1'b1; after2 = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int c = 0; c < 16; c++) begin
      tick();
      dREN = 1'b1; ramstate = BUSY;
      #2;
      if (ramREN && g0 < 0) g0 = c;
      if (arb_timeout) begin pulses++; if (first < 0) first = c; end
      if (!dwait) dlow = 1'b1;
      if (first >= 0 && c == first + 1) after1 = ramREN;
      if (first >= 0 && c == first + 2) after2 = ramREN;
    end
    check("wd_pulse_cycle", 128'(first - g0), 128'(8));
    check("wd_pulse_count", 128'(pulses), 128'(1));
    check("wd_dwait_held", 128'(dlow), 128'(1'b0));
    check("wd_idle_then_regrant", 128'({after1, after2}), 128'({1'b0, 1'b1}));
`else
    for (int c = 0; c < 40; c++) begin
      tick();
      dREN = 1'b1; ramstate = BUSY;
      #2;
      if (ramREN && g0 < 0) g0 = c;
      if (arb_timeout) pulses++;
      if (!dwait) dlow = 1'b1;
      if (g0 >= 0 && !ramREN) held = 1'b0;
    end
    check("nowd_grant_seen", 128'(g0), 128'(1));
    check("nowd_no_pulse", 128'(pulses), 128'(0));
    check("nowd_grant_held", 128'({held, dlow}), 128'({1'b1, 1'b0}));
`endif
    dREN = 1'b0; ramstate = FREE;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the icache and the dcache.
- Sits between the cache block (icache/dcache miss ports) and the RAM model or bus.
- Holds one grant per transaction, gives the dcache priority, and uses a starvation counter so the icache is always served eventually.
- Returns wait/load to the requester that holds the grant.

Parameters:
STARVE_MAX, 4, consecutive dcache grants allowed while iREN pending before icache is forced next (1..15)
TIMEOUT, 255, max cycles in a grant state without ACCESS before abort (used only with MEM_ARB_TIMEOUT_EN)

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  icache read request
iaddr  in  32  icache word address
iwait  out  1  high = icache must wait; low for exactly the completion cycle
iload  out  32  icache read data, valid when iwait low
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  32  dcache word address
dstore  in  32  dcache write data
dwait  out  1  high = dcache must wait; low for exactly the completion cycle
dload  out  32  dcache read data, valid when dwait low
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
arb_timeout  out  1  one-cycle pulse on watchdog abort (tied 0 without macro)

Behaviour:
- Reset (nRST low, async):
  - state=IDLE, starve_cnt=0, timer=0.
  - iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, arb_timeout=0.
- States: IDLE, DGRANT, IGRANT. State register updates on CLK rise; all outputs are combinational from state and inputs.
- IDLE:
  - No RAM enables; iwait=dwait=1.
  - Next state: if (dREN|dWEN) and !(iREN && starve_cnt==STARVE_MAX), go to DGRANT; else if iREN, go to IGRANT; else stay IDLE.
- DGRANT:
  - ramaddr=daddr, ramstore=dstore.
  - If dWEN: ramWEN=1, ramREN=0 (write wins if both enables are high). Else ramREN=dREN.
  - iwait=1.
  - dwait=0 and dload=ramload only when ramstate==ACCESS.
- IGRANT:
  - ramaddr=iaddr, ramREN=1, ramWEN=0, dwait=1.
  - iwait=0 and iload=ramload only when ramstate==ACCESS.
- Completion: ramstate==ACCESS while granted. Next state is IDLE, so there is one idle bubble cycle between transactions.
- Minimum latency from request to completion: 2 cycles. Request seen in IDLE at cycle 0, RAM enables high at cycle 1, completion no earlier than cycle 1.
- Requester drops its request while granted (dREN=dWEN=0 in DGRANT, or iREN=0 in IGRANT):
  - Abort: RAM enables go low that same cycle, next state IDLE.
  - No wait-low is issued and starve_cnt is unchanged.
- ramstate==ERROR while granted:
  - Requester's wait stays 1, next state IDLE.
  - The requester is re-arbitrated (retry). starve_cnt is unchanged.
- starve_cnt (4 bits):
  - Increments on each DGRANT completion when iREN==1; saturates at STARVE_MAX.
  - Clears on IGRANT completion, and in any cycle where iREN==0.
- iload/dload carry ramload whenever their requester is granted. Content is don't-care while the corresponding wait is 1.
- Address and data from the granted requester must be held stable until its wait goes low. The arbiter does not latch them.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - An 8-bit timer clears on entry to DGRANT/IGRANT and increments each cycle in a grant state without ACCESS.
  - When timer==TIMEOUT: abort to IDLE, pulse arb_timeout=1 for one cycle. The requester's wait stays 1.
  - starve_cnt increments as if a DGRANT completed, so a hung dcache access cannot starve the icache.
- Undefined: no timer logic; arb_timeout held 0; a grant state is held indefinitely until ACCESS, ERROR or request drop.

Test Plan:
- iREN=1, iaddr=0x00000040, RAM returns ACCESS on 2nd grant cycle with ramload=0x8C010004 -> ramREN=1, ramaddr=0x40 for 2 cycles; iwait=0, iload=0x8C010004 in the ACCESS cycle; IDLE next.
- iREN and dWEN both raised at cycle 0, daddr=0x100, dstore=0xDEADBEEF -> DGRANT first with ramWEN=1, ramstore=0xDEADBEEF; after dwait low, idle bubble, then IGRANT.
- dREN held continuously, iREN held, STARVE_MAX=4 -> exactly 4 dcache completions, then IGRANT; starve_cnt reads 0 after the icache completion.
- dREN dropped on 2nd DGRANT cycle while ramstate=BUSY -> ramREN=0 that cycle, dwait stays 1, state IDLE next, starve_cnt unchanged.
- nRST asserted mid-DGRANT (ramstate=BUSY) -> ramREN/ramWEN=0 and dwait=1 immediately (async), state IDLE; after release the pending dREN is re-granted.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=8, ramstate stuck BUSY -> arb_timeout pulses 1 cycle 8 cycles after grant entry; dwait remains 1; grant re-issued after the IDLE cycle.
